// File: rtl/mc_cpu.sv
// ============================================================================
// Module      : mc_cpu
// Description : Multi-cycle CPU core with FETCH/EXEC/MEM/HALT sequencing,
//               eight flagged registers and a wait-state tolerant memory port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_cpu #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clock,
   input  logic              reset,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              halted,
   output logic [ADDR_W-1:0] pc,
   output logic              illegal
);

   typedef enum logic [1:0] {
      ST_FETCH = 2'd0,
      ST_EXEC  = 2'd1,
      ST_MEM   = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam logic [5:0] c_op_nop  = 6'd0;
   localparam logic [5:0] c_op_add  = 6'd1;
   localparam logic [5:0] c_op_sub  = 6'd2;
   localparam logic [5:0] c_op_and  = 6'd3;
   localparam logic [5:0] c_op_or   = 6'd4;
   localparam logic [5:0] c_op_xor  = 6'd5;
   localparam logic [5:0] c_op_ldi  = 6'd6;
   localparam logic [5:0] c_op_st   = 6'd7;
   localparam logic [5:0] c_op_ld   = 6'd8;
   localparam logic [5:0] c_op_br   = 6'd9;
   localparam logic [5:0] c_op_halt = 6'd10;

   localparam logic [DATA_W-1:0] c_hi_mask = DATA_W'(17'h0FFFF) << (DATA_W - 16);

   state_t              r_state;
   state_t              w_state_next;
   logic [31:0]         r_instr;
   logic [ADDR_W-1:0]   r_pc;
   logic [DATA_W-1:0]   r_regs [8];
   logic [7:0]          r_flags;
   logic                r_illegal;

   logic [5:0]          w_op;
   logic [2:0]          w_ra_sel;
   logic [2:0]          w_rb_sel;
   logic [2:0]          w_rd_sel;
   logic                w_hl;
   logic [15:0]         w_imm;
   logic [DATA_W-1:0]   w_ra;
   logic [DATA_W-1:0]   w_rb;
   logic [ADDR_W-1:0]   w_ra_addr;
   logic [31:0]         w_fetch_instr;
   logic                w_mem_req;
   logic                w_xfer;
   logic                w_is_st;

   logic [DATA_W:0]     w_sum;
   logic [DATA_W-1:0]   w_diff;
   logic [DATA_W-1:0]   w_logic;
   logic [DATA_W-1:0]   w_imm_lo;
   logic [DATA_W-1:0]   w_imm_hi;

   logic                w_reg_we;
   logic [DATA_W-1:0]   w_reg_wdata;
   logic                w_flag_we;
   logic                w_flag_wdata;
   logic                w_pc_we;
   logic [ADDR_W-1:0]   w_pc_next;
   logic                w_set_illegal;

   assign w_op     = r_instr[5:0];
   assign w_ra_sel = r_instr[8:6];
   assign w_rb_sel = r_instr[11:9];
   assign w_rd_sel = r_instr[14:12];
   assign w_hl     = r_instr[15];
   assign w_imm    = r_instr[31:16];

   assign w_ra = r_regs[w_ra_sel];
   assign w_rb = r_regs[w_rb_sel];

   // Register value used as an address: zero-extend or truncate to ADDR_W.
   generate
      if (ADDR_W > DATA_W) begin : g_addr_wide
         assign w_ra_addr = {{(ADDR_W - DATA_W){1'b0}}, w_ra};
      end else begin : g_addr_narrow
         assign w_ra_addr = w_ra[ADDR_W-1:0];
      end
   endgenerate

   generate
      if (DATA_W >= 32) begin : g_instr_wide
         assign w_fetch_instr = mem_rdata[31:0];
      end else begin : g_instr_narrow
         assign w_fetch_instr = {{(32 - DATA_W){1'b0}}, mem_rdata};
      end
   endgenerate

   assign w_is_st   = (w_op == c_op_st);
   assign w_mem_req = ((r_state == ST_FETCH) || (r_state == ST_MEM)) && !reset;
   assign w_xfer    = w_mem_req && mem_ack;

   assign w_sum    = {1'b0, w_ra} + {1'b0, w_rb};
   assign w_diff   = w_ra - w_rb;
   assign w_imm_lo = DATA_W'(w_imm);
   assign w_imm_hi = DATA_W'(w_imm) << (DATA_W - 16);

   always_comb begin
      w_logic = '0;
      case (w_op)
         c_op_and: w_logic = w_ra & w_rb;
         c_op_or:  w_logic = w_ra | w_rb;
         c_op_xor: w_logic = w_ra ^ w_rb;
         default:  w_logic = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state <= ST_FETCH;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_FETCH: begin
            if (w_xfer) begin
               w_state_next = ST_EXEC;
            end
         end
         ST_EXEC: begin
            if ((w_op == c_op_st) || (w_op == c_op_ld)) begin
               w_state_next = ST_MEM;
            end else if (w_op == c_op_halt) begin
               w_state_next = ST_HALT;
            end else begin
               w_state_next = ST_FETCH;
            end
         end
         ST_MEM: begin
            if (w_xfer) begin
               w_state_next = ST_FETCH;
            end
         end
         default: w_state_next = ST_HALT;
      endcase
   end

   always_comb begin
      w_reg_we      = 1'b0;
      w_reg_wdata   = '0;
      w_flag_we     = 1'b0;
      w_flag_wdata  = 1'b0;
      w_pc_we       = 1'b0;
      w_pc_next     = r_pc;
      w_set_illegal = 1'b0;
      case (r_state)
         ST_FETCH: begin
            if (w_xfer) begin
               w_pc_we   = 1'b1;
               w_pc_next = r_pc + ADDR_W'(1);
            end
         end
         ST_EXEC: begin
            case (w_op)
               c_op_nop, c_op_st, c_op_ld, c_op_halt: begin
               end
               c_op_add: begin
                  w_reg_we     = 1'b1;
                  w_reg_wdata  = w_sum[DATA_W-1:0];
                  w_flag_we    = 1'b1;
                  w_flag_wdata = w_sum[DATA_W];
               end
               c_op_sub: begin
                  w_reg_we     = 1'b1;
                  w_reg_wdata  = w_diff;
                  w_flag_we    = 1'b1;
                  w_flag_wdata = (w_ra < w_rb);
               end
               c_op_and, c_op_or, c_op_xor: begin
                  w_reg_we     = 1'b1;
                  w_reg_wdata  = w_logic;
                  w_flag_we    = 1'b1;
                  w_flag_wdata = (w_logic == '0);
               end
               c_op_ldi: begin
                  w_reg_we    = 1'b1;
                  w_reg_wdata = w_hl ? ((r_regs[w_rd_sel] & ~c_hi_mask) | w_imm_hi)
                                     : w_imm_lo;
               end
               c_op_br: begin
                  if (!w_hl || r_flags[w_rb_sel]) begin
                     w_pc_we   = 1'b1;
                     w_pc_next = w_ra_addr;
                  end
               end
               default: w_set_illegal = 1'b1;
            endcase
         end
         ST_MEM: begin
            if (w_xfer && (w_op == c_op_ld)) begin
               w_reg_we    = 1'b1;
               w_reg_wdata = mem_rdata;
            end
         end
         default: begin
         end
      endcase
   end

   // Reset takes priority over every architectural update on the same edge.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_pc      <= RESET_PC;
         r_instr   <= '0;
         r_flags   <= '0;
         r_illegal <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_regs[i] <= '0;
         end
      end else begin
         if ((r_state == ST_FETCH) && w_xfer) begin
            r_instr <= w_fetch_instr;
         end
         if (w_pc_we) begin
            r_pc <= w_pc_next;
         end
         if (w_reg_we) begin
            r_regs[w_rd_sel] <= w_reg_wdata;
         end
         if (w_flag_we) begin
            r_flags[w_rd_sel] <= w_flag_wdata;
         end
         if (w_set_illegal) begin
            r_illegal <= 1'b1;
         end
      end
   end

   assign mem_req   = w_mem_req;
   assign mem_we    = (r_state == ST_MEM) && w_is_st && !reset;
   assign mem_addr  = (r_state == ST_MEM) ? w_ra_addr : r_pc;
   assign mem_wdata = ((r_state == ST_MEM) && w_is_st) ? w_rb : '0;
   assign halted    = (r_state == ST_HALT);
   assign pc        = r_pc;
   assign illegal   = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_mc_cpu.sv
// ============================================================================
// Module      : tb_mc_cpu
// Description : Directed-program bench for mc_cpu with a store scoreboard.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_cpu;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic        halted;
   logic [31:0] pc;
   logic        illegal;

   logic [31:0] mem [256];
   logic [63:0] exp_q [$];
   int          checks;
   int          failures;
   logic        ld_ack_seen;

   mc_cpu #(
      .DATA_W   (32),
      .ADDR_W   (32),
      .RESET_PC (32'h0)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ack   (mem_ack),
      .halted    (halted),
      .pc        (pc),
      .illegal   (illegal)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [2:0] ra,
                                       input logic [2:0] rb, input logic [2:0] rd,
                                       input logic hl, input logic [15:0] imm);
      return {imm, hl, rd, rb, ra, op};
   endfunction

   function automatic logic [31:0] ldi(input logic [2:0] rd, input logic [15:0] imm);
      return enc(6'd6, 3'd0, 3'd0, rd, 1'b0, imm);
   endfunction

   function automatic logic [31:0] ldih(input logic [2:0] rd, input logic [15:0] imm);
      return enc(6'd6, 3'd0, 3'd0, rd, 1'b1, imm);
   endfunction

   function automatic logic [31:0] alu(input logic [5:0] op, input logic [2:0] rd,
                                       input logic [2:0] ra, input logic [2:0] rb);
      return enc(op, ra, rb, rd, 1'b0, 16'h0);
   endfunction

   function automatic logic [31:0] st(input logic [2:0] ra, input logic [2:0] rb);
      return enc(6'd7, ra, rb, 3'd0, 1'b0, 16'h0);
   endfunction

   function automatic logic [31:0] ld(input logic [2:0] rd, input logic [2:0] ra);
      return enc(6'd8, ra, 3'd0, rd, 1'b0, 16'h0);
   endfunction

   function automatic logic [31:0] br(input logic hl, input logic [2:0] ra, input logic [2:0] rb);
      return enc(6'd9, ra, rb, 3'd0, hl, 16'h0);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic push_st(input logic [31:0] addr, input logic [31:0] data);
      exp_q.push_back({addr, data});
   endtask

   // Memory responder and store monitor: data space (>=0x80) has 3 wait states.
   task automatic monitor_loop();
      int          hold_cnt;
      int          waits;
      logic [31:0] cap_addr;
      logic [31:0] cap_wdata;
      logic        cap_we;
      logic [63:0] e;
      hold_cnt  = 0;
      cap_addr  = '0;
      cap_wdata = '0;
      cap_we    = 1'b0;
      forever begin
         @(negedge clock);
         if (mem_req) begin
            if (hold_cnt == 0) begin
               cap_addr  = mem_addr;
               cap_we    = mem_we;
               cap_wdata = mem_wdata;
            end else begin
               chk("req_hold", {mem_addr, mem_wdata}, {cap_addr, cap_wdata});
               chk("we_hold", {63'd0, mem_we}, {63'd0, cap_we});
            end
            waits = (mem_addr >= 32'h80) ? 3 : 0;
            if (hold_cnt == waits) begin
               mem_ack   = 1'b1;
               mem_rdata = mem[mem_addr[7:0]];
               hold_cnt  = 0;
               if (mem_we) begin
                  if (exp_q.size() == 0) begin
                     chk("store_unexpected", {mem_addr, mem_wdata}, 64'h0);
                  end else begin
                     e = exp_q.pop_front();
                     chk("store", {mem_addr, mem_wdata}, e);
                  end
               end else if (mem_addr == 32'h91) begin
                  ld_ack_seen = 1'b1;
               end
            end else begin
               mem_ack   = 1'b0;
               mem_rdata = 32'hDEAD_BEEF;
               hold_cnt++;
            end
         end else begin
            mem_ack   = 1'b0;
            mem_rdata = 32'hDEAD_BEEF;
            hold_cnt  = 0;
         end
      end
   endtask

   task automatic wait_halt(input int max_cycles);
      for (int i = 0; i < max_cycles; i++) begin
         @(negedge clock);
         #1;
         if (halted) break;
      end
      chk("halt_reached", {63'd0, halted}, 64'd1);
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) begin
         mem[i] = 32'h0;
      end
   endtask

   task automatic load_prog_a();
      clear_mem();
      mem[0]  = ldi(3'd1, 16'd5);
      mem[1]  = ldi(3'd2, 16'd3);
      mem[2]  = alu(6'd1, 3'd3, 3'd1, 3'd2);
      mem[3]  = ldi(3'd6, 16'h80);
      mem[4]  = st(3'd6, 3'd3);
      mem[5]  = ldi(3'd5, 16'd20);
      mem[6]  = br(1'b1, 3'd5, 3'd3);
      mem[7]  = st(3'd6, 3'd1);
      mem[8]  = ldi(3'd1, 16'hFFFF);
      mem[9]  = ldih(3'd1, 16'hFFFF);
      mem[10] = ldi(3'd2, 16'd1);
      mem[11] = alu(6'd1, 3'd4, 3'd1, 3'd2);
      mem[12] = st(3'd6, 3'd4);
      mem[13] = alu(6'd2, 3'd5, 3'd2, 3'd1);
      mem[14] = st(3'd6, 3'd5);
      mem[15] = ldi(3'd7, 16'd18);
      mem[16] = br(1'b1, 3'd7, 3'd4);
      mem[17] = st(3'd6, 3'd6);
      mem[18] = ldi(3'd7, 16'd21);
      mem[19] = br(1'b1, 3'd7, 3'd5);
      mem[20] = st(3'd6, 3'd6);
      mem[21] = ldi(3'd7, 16'h1234);
      mem[22] = ldih(3'd7, 16'hABCD);
      mem[23] = st(3'd6, 3'd7);
      mem[24] = ld(3'd0, 3'd6);
      mem[25] = ldi(3'd6, 16'h81);
      mem[26] = st(3'd6, 3'd0);
      mem[27] = alu(6'd5, 3'd2, 3'd1, 3'd1);
      mem[28] = ldi(3'd3, 16'd31);
      mem[29] = br(1'b1, 3'd3, 3'd2);
      mem[30] = st(3'd6, 3'd6);
      mem[31] = alu(6'd3, 3'd2, 3'd1, 3'd1);
      mem[32] = ldi(3'd3, 16'd40);
      mem[33] = br(1'b1, 3'd3, 3'd2);
      mem[34] = st(3'd6, 3'd2);
      mem[35] = enc(6'h3F, 3'd1, 3'd1, 3'd2, 1'b0, 16'h1111);
      mem[36] = st(3'd6, 3'd2);
      mem[37] = ldi(3'd5, 16'd40);
      mem[38] = br(1'b0, 3'd5, 3'd0);
      mem[39] = st(3'd6, 3'd6);
      mem[40] = alu(6'd4, 3'd4, 3'd0, 3'd3);
      mem[41] = st(3'd6, 3'd4);
      mem[42] = enc(6'd10, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
      mem[8'h80] = 32'hABCD_1234;
   endtask

   initial begin
      logic req_seen;
      logic ld_found;
      checks      = 0;
      failures    = 0;
      ld_ack_seen = 1'b0;
      reset       = 1'b1;
      mem_ack     = 1'b0;
      mem_rdata   = 32'h0;
      load_prog_a();
      push_st(32'h80, 32'd8);
      push_st(32'h80, 32'd5);
      push_st(32'h80, 32'd0);
      push_st(32'h80, 32'd2);
      push_st(32'h80, 32'hABCD_1234);
      push_st(32'h81, 32'hABCD_1234);
      push_st(32'h81, 32'hFFFF_FFFF);
      push_st(32'h81, 32'hFFFF_FFFF);
      push_st(32'h81, 32'hABCD_123C);
      fork
         monitor_loop();
      join_none

      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      chk("reset_req", {63'd0, mem_req}, 64'd0);
      chk("reset_pc", {32'd0, pc}, 64'd0);
      chk("reset_flags_out", {62'd0, halted, illegal}, 64'd0);
      @(posedge clock);
      #2 reset = 1'b0;

      @(negedge clock);
      #1;
      chk("first_fetch", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'd0});
      @(negedge clock);
      #1;
      chk("exec_no_req", {63'd0, mem_req}, 64'd0);
      repeat (5) @(negedge clock);
      #1;
      chk("add_done_fetch3", {30'd0, mem_req, mem_we, mem_addr}, {30'd0, 2'b10, 32'd3});

      wait_halt(3000);
      chk("illegal_sticky", {63'd0, illegal}, 64'd1);
      chk("halt_pc", {32'd0, pc}, 64'd43);
      req_seen = 1'b0;
      repeat (20) begin
         @(negedge clock);
         #1;
         if (mem_req) req_seen = 1'b1;
      end
      chk("halt_no_req", {63'd0, req_seen}, 64'd0);
      chk("sb_empty_a", 64'(exp_q.size()), 64'd0);

      // Second program: reset lands on the edge that acknowledges a load.
      @(posedge clock);
      #2 reset = 1'b1;
      clear_mem();
      mem[0] = ldi(3'd6, 16'h91);
      mem[1] = ldi(3'd1, 16'h77);
      mem[2] = ld(3'd1, 3'd6);
      mem[3] = enc(6'd10, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
      mem[8'h91] = 32'h5555_5555;
      @(negedge clock);
      #1;
      chk("reset2_req", {63'd0, mem_req}, 64'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      #1;
      chk("reset2_state", {30'd0, halted, illegal, pc}, 64'd0);

      ld_found = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         #1;
         if (ld_ack_seen) begin
            ld_found = 1'b1;
            break;
         end
      end
      chk("ld_ack_found", {63'd0, ld_found}, 64'd1);
      reset = 1'b1;
      @(negedge clock);
      #1;
      chk("ld_reset_pc", {32'd0, pc}, 64'd0);
      chk("ld_reset_req", {62'd0, mem_req, halted}, 64'd0);
      clear_mem();
      mem[0] = ldi(3'd6, 16'hA0);
      mem[1] = st(3'd6, 3'd1);
      mem[2] = enc(6'd10, 3'd0, 3'd0, 3'd0, 1'b0, 16'h0);
      push_st(32'hA0, 32'd0);
      @(posedge clock);
      #2 reset = 1'b0;
      @(negedge clock);
      #1;
      chk("restart_fetch", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, 32'd0});
      wait_halt(500);
      chk("halt_pc_c", {32'd0, pc}, 64'd3);
      chk("sb_empty_c", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mc_cpu.md
# mc_cpu

Parametrised multi-cycle CPU core: the successor to the single-cycle `cpu` block. It has configurable data and address width, eight general registers each with a one-bit flag, and a request/acknowledge memory port that tolerates any number of wait states. It keeps the existing 32-bit instruction field layout and adds a formal FETCH/EXEC/MEM/HALT state machine, branches and halt. It sits between the instruction/data memory and the system top level.

## Interface
- DATA_W, 32, datapath and register width; legal range 16..64
- ADDR_W, 32, memory address width; PC width
- RESET_PC, 0, PC value loaded by reset
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high; clears core on the rising edge where it is high
- mem_req  out  1  memory access request; high in FETCH and MEM, low in EXEC, HALT and while reset is high
- mem_we  out  1  write strobe; high only in MEM for ST
- mem_addr  out  ADDR_W  access address
- mem_wdata  out  DATA_W  store data; rb value during ST, else 0
- mem_rdata  in  DATA_W  read data, valid when mem_ack is high
- mem_ack  in  1  access completes on the rising edge where mem_req and mem_ack are both high; ack while mem_req is low is ignored
- halted  out  1  high in HALT state
- pc  out  ADDR_W  current program counter
- illegal  out  1  sticky; set on decode of an undefined opcode

## Operation
- Instruction fields: op=[5:0], ra=[8:6], rb=[11:9], rd=[14:12], hl=[15], imm=[31:16]. ra and rb select source registers; flag[x] is the flag of register x.
- FETCH: mem_addr=pc, mem_we=0. On ack: latch instr=mem_rdata[31:0], pc<=pc+1 (wraps modulo 2^ADDR_W), go to EXEC.
- EXEC, one cycle:
  - op 0 NOP: no state change.
  - op 1 ADD: rd=ra+rb; flag[rd]=carry out of bit DATA_W-1.
  - op 2 SUB: rd=ra-rb; flag[rd]=borrow (ra<rb unsigned).
  - op 3 AND, op 4 OR, op 5 XOR: rd=result; flag[rd]=(result==0).
  - op 6 LDI: if hl=0, rd=zero-extended imm. If hl=1, rd[DATA_W-1:DATA_W-16]=imm and the low bits are kept. flag unchanged.
  - op 7 ST, op 8 LD: go to MEM.
  - op 9 BR: if hl=0, pc<=ra[ADDR_W-1:0]. If hl=1, branch only when flag[rb]=1. ra is zero-extended when ADDR_W>DATA_W.
  - op 10 HALT: go to HALT.
  - Other opcodes: treated as NOP; illegal<=1.
  - Every op except ST/LD/HALT returns to FETCH.
- MEM: mem_addr=ra (truncated or zero-extended to ADDR_W).
  - ST: mem_we=1, mem_wdata=rb.
  - LD: on ack, rd=mem_rdata; flag unchanged.
  - On ack, go to FETCH.
- HALT: no requests; remains in HALT until reset.
- Register read and write to the same register in one EXEC: the read uses the old value; the write lands at the cycle-end edge.
- Reset values: pc=RESET_PC, r0..r7=0, flags=0, instr=0, illegal=0, state=FETCH. In the cycle after reset deasserts, mem_req=1 and mem_addr=RESET_PC.
- Reset asserted mid-access (FETCH or MEM, before or with ack): the access is abandoned and no register or pc update occurs. Reset wins over every other update on the same edge.

## Timing
- With zero wait states (ack in the same cycle as req): ALU, LDI, BR, NOP and illegal ops take 2 cycles; LD and ST take 3 cycles. Each wait state adds one cycle.
- All outputs are registered-state decodes. mem_req, mem_we, mem_addr and mem_wdata are stable for the whole request until ack.
- A branch target takes effect on the next FETCH address. A taken branch has no delay slot.
- HALT: halted=1 from the cycle after HALT executes.

## Test plan
- Reset, then LDI r1,0x0005; LDI r2,0x0003; ADD r3=r1+r2 with zero-wait memory -> r3=8, flag[3]=0. ADD completes 6 cycles after the first fetch begins.
- LDI r1,0xFFFF; LDI hl=1 r1,0xFFFF; LDI r2,1; ADD r4=r1+r2 (DATA_W=32) -> r4=0, flag[4]=1. Then SUB r5=r2-r1 -> flag[5]=1.
- ST mem[r6]=r7 then LD r0=mem[r6] with ack delayed 3 cycles per access -> mem_req, mem_addr and mem_wdata held through the wait states, mem_we high only for the ST, r0=r7.
- XOR r2=r1^r1 (flag[2]=1), then BR hl=1 ra=r3 rb=r2 -> next fetch address=r3. With flag[2]=0 -> next fetch address=old pc+1.
- Opcode 0x3F -> illegal=1, registers unchanged, execution continues. HALT -> halted=1, mem_req=0 for 20 cycles. Reset -> pc=RESET_PC, illegal=0.
- Assert reset on the same edge as a LD ack -> rd not written, state=FETCH, pc=RESET_PC.
